// File: rtl/addsub_bk_pipe_16b_if.sv
// Operand/result bus of the pipelined 16-bit add/sub unit.
// The master side supplies operands and consumes results. The slave side is the unit itself.
interface addsub_bk_pipe_16b_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  op_i;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        carry_in_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] sum_o;
    logic        flag_n_o;
    logic        flag_z_o;
    logic        flag_c_o;
    logic        flag_v_o;

    modport master (
        output in_valid_i, op_i, a_i, b_i, carry_in_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o, flag_n_o, flag_z_o, flag_c_o, flag_v_o
    );

    modport slave (
        input  in_valid_i, op_i, a_i, b_i, carry_in_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o, flag_n_o, flag_z_o, flag_c_o, flag_v_o
    );
endinterface

// File: rtl/addsub_bk_pipe_16b.sv
// Two-stage pipelined 16-bit add/subtract unit with NZCV flags and valid/ready on both sides.
// Carries come from a Brent-Kung prefix tree. The operand carry-in is folded into bit 0's generate.
module carry_tree_bk_16b (
    input  logic [15:0] prop_i,
    input  logic [15:0] gen_i,
    output logic [15:0] carry_o
);
    logic [15:0] gg;
    logic [15:0] pp;

    // NOTE: blocking assignments here, because each prefix level reads the level just computed.
    always_comb begin
        gg = gen_i;
        pp = prop_i;
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 16; i++) begin
                if ((i + 1) % (2 << d) == 0) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
                    pp[i] = pp[i] & pp[i - (1 << d)];
                end
            end
        end
        for (int d = 2; d >= 0; d--) begin
            for (int i = 0; i < 16; i++) begin
                if ((i >= (3 << d) - 1) && ((i + 1 - (1 << d)) % (2 << d) == 0)) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
                end
            end
        end
        carry_o = gg;
    end
endmodule

module addsub_bk_pipe_16b (
    input logic                 clk_i,
    input logic                 rst_i,
    addsub_bk_pipe_16b_if.slave bus
);
    logic        adv1;
    logic        adv2;
    logic [15:0] b_eff;
    logic        cin;
    logic [15:0] p_in;
    logic [15:0] g_in;

    logic        s1_valid;
    logic [15:0] s1_p;
    logic [15:0] s1_g;
    logic        s1_cin;

    logic [15:0] carry;
    logic [15:0] sum_nxt;

    assign adv2          = !bus.out_valid_o || bus.out_ready_i;
    assign adv1          = !s1_valid || adv2;
    assign bus.in_ready_o = adv1 && !rst_i;

    // op_i[0] selects subtraction; op_i[1] selects the external carry.
    assign b_eff = bus.op_i[0] ? ~bus.b_i : bus.b_i;
    assign cin   = bus.op_i[1] ? bus.carry_in_i : bus.op_i[0];
    assign p_in  = bus.a_i ^ b_eff;
    assign g_in  = {bus.a_i[15:1] & b_eff[15:1], (bus.a_i[0] & b_eff[0]) | (p_in[0] & cin)};

    // NOTE: the datapath registers are not reset. Only the valid bits and the visible outputs are cleared.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                s1_p   <= p_in;
                s1_g   <= g_in;
                s1_cin <= cin;
            end
        end
    end

    carry_tree_bk_16b u_tree (
        .prop_i  (s1_p),
        .gen_i   (s1_g),
        .carry_o (carry)
    );

    assign sum_nxt = s1_p ^ {carry[14:0], s1_cin};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.out_valid_o <= 1'b0;
            bus.sum_o       <= 16'h0000;
            bus.flag_n_o    <= 1'b0;
            bus.flag_z_o    <= 1'b0;
            bus.flag_c_o    <= 1'b0;
            bus.flag_v_o    <= 1'b0;
        end else if (adv2) begin
            bus.out_valid_o <= s1_valid;
            if (s1_valid) begin
                bus.sum_o    <= sum_nxt;
                bus.flag_n_o <= sum_nxt[15];
                bus.flag_z_o <= (sum_nxt == 16'h0000);
                bus.flag_c_o <= carry[15];
                bus.flag_v_o <= carry[15] ^ carry[14];
            end
        end
    end
endmodule

// File: tb/tb_addsub_bk_pipe_16b.sv
// Bench for addsub_bk_pipe_16b: directed vectors, backpressure, reset mid-flight and a randomized scoreboard run.
// Result words are packed as {N, Z, C, V, sum[15:0]}.
module tb_addsub_bk_pipe_16b;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    addsub_bk_pipe_16b_if bus ();

    addsub_bk_pipe_16b dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] ADC = 2'b10;
    localparam logic [1:0] SBC = 2'b11;
    localparam int N_BEATS = 10000;

    int n_cmp = 0;
    int n_mis = 0;
    logic [19:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] result_word();
        return {bus.flag_n_o, bus.flag_z_o, bus.flag_c_o, bus.flag_v_o, bus.sum_o};
    endfunction

    function automatic logic [19:0] model(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic ci);
        logic [15:0] be;
        logic [16:0] r;
        logic        c0;
        logic        v;
        be = op[0] ? ~b : b;
        c0 = op[1] ? ci : op[0];
        r  = {1'b0, a} + {1'b0, be} + {16'h0000, c0};
        v  = (a[15] == be[15]) && (r[15] != a[15]);
        return {r[15], r[15:0] == 16'h0000, r[16], v, r[15:0]};
    endfunction

    task automatic drive(input logic vld, input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic ci);
        bus.in_valid_i = vld;
        bus.op_i       = op;
        bus.a_i        = a;
        bus.b_i        = b;
        bus.carry_in_i = ci;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends one time unit after a rising edge. Sends one beat with no backpressure.
    task automatic run_one(input string tag, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic ci, input logic [19:0] exp);
        bus.out_ready_i = 1'b1;
        drive(1'b1, op, a, b, ci);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd1);
        step();
        drive(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        check({tag, "_valid_early"}, 32'(bus.out_valid_o), 32'd0);
        step();
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
        check({tag, "_result"}, 32'(result_word()), 32'(exp));
        step();
    endtask

    initial begin
        bus.out_ready_i = 1'b0;
        drive(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);

        repeat (2) step();
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check("rst_result", 32'(result_word()), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 32'(bus.in_ready_o), 32'd1);
        step();

        run_one("add_wrap", ADD, 16'hFFFF, 16'h0001, 1'b0, 20'h60000);
        run_one("add_ovf",  ADD, 16'h7FFF, 16'h0001, 1'b0, 20'h98000);
        run_one("sub_ovf",  SUB, 16'h8000, 16'h0001, 1'b0, 20'h37FFF);
        run_one("sbc_brw",  SBC, 16'h0000, 16'h0001, 1'b1, 20'h8FFFF);
        run_one("adc_cin",  ADC, 16'h1234, 16'h0001, 1'b1, 20'h01236);
        run_one("sub_zero", SUB, 16'h0005, 16'h0005, 1'b0, 20'h60000);
        run_one("adc_ncin", ADC, 16'h00FF, 16'h0001, 1'b0, 20'h00100);

        // Backpressure: three back-to-back beats into a stalled sink.
        bus.out_ready_i = 1'b0;
        drive(1'b1, ADD, 16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        check("bp_rdy1", 32'(bus.in_ready_o), 32'd1);
        step();
        drive(1'b1, ADD, 16'h0002, 16'h0002, 1'b0);
        @(negedge clk);
        check("bp_rdy2", 32'(bus.in_ready_o), 32'd1);
        step();
        drive(1'b1, ADD, 16'h0003, 16'h0003, 1'b0);
        @(negedge clk);
        check("bp_full", 32'(bus.in_ready_o), 32'd0);
        check("bp_valid", 32'(bus.out_valid_o), 32'd1);
        check("bp_sum", 32'(bus.sum_o), 32'h0002);
        step();
        @(negedge clk);
        check("bp_still_full", 32'(bus.in_ready_o), 32'd0);
        check("bp_hold", 32'(bus.sum_o), 32'h0002);
        step();
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        check("bp_rdy_comb", 32'(bus.in_ready_o), 32'd1);
        check("bp_out0", 32'({bus.out_valid_o, bus.sum_o}), 32'h10002);
        step();
        drive(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        check("bp_out1", 32'({bus.out_valid_o, bus.sum_o}), 32'h10004);
        step();
        @(negedge clk);
        check("bp_out2", 32'({bus.out_valid_o, bus.sum_o}), 32'h10006);
        step();
        @(negedge clk);
        check("bp_empty", 32'(bus.out_valid_o), 32'd0);
        step();

        // Reset with two beats in flight.
        drive(1'b1, ADD, 16'h1111, 16'h1111, 1'b0);
        step();
        drive(1'b1, ADD, 16'h2222, 16'h2222, 1'b0);
        step();
        drive(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mr_in_ready", 32'(bus.in_ready_o), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mr_valid", 32'(bus.out_valid_o), 32'd0);
        check("mr_result", 32'(result_word()), 32'd0);
        check("mr_in_ready_rel", 32'(bus.in_ready_o), 32'd1);
        step();
        @(negedge clk);
        check("mr_no_stale", 32'(bus.out_valid_o), 32'd0);
        step();
        run_one("mr_next", SUB, 16'h0010, 16'h0020, 1'b0, 20'h8FFF0);

        // Random traffic against the behavioural model.
        begin
            int sent = 0;
            int recv = 0;
            int cyc = 0;
            logic held_vld = 1'b0;
            logic [19:0] held = '0;
            while (recv < N_BEATS && cyc < 60000) begin
                cyc++;
                if (sent < N_BEATS && $urandom_range(0, 3) != 0)
                    drive(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
                else
                    drive(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);
                bus.out_ready_i = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (held_vld)
                    check("rnd_stall_hold", 32'({bus.out_valid_o, result_word()}), 32'({1'b1, held}));
                held_vld = bus.out_valid_o && !bus.out_ready_i;
                held     = result_word();
                if (bus.in_valid_i && bus.in_ready_o) begin
                    exp_q.push_back(model(bus.op_i, bus.a_i, bus.b_i, bus.carry_in_i));
                    sent++;
                end
                if (bus.out_valid_o && bus.out_ready_i) begin
                    recv++;
                    if (exp_q.size() == 0)
                        check("rnd_extra_beat", 32'(result_word()), 32'hFFFFFFFF);
                    else
                        check("rnd_result", 32'(result_word()), 32'(exp_q.pop_front()));
                end
                step();
            end
            drive(1'b0, ADD, 16'h0000, 16'h0000, 1'b0);
            check("rnd_recv_count", 32'(recv), 32'(N_BEATS));
            check("rnd_sent_count", 32'(sent), 32'(N_BEATS));
            check("rnd_queue_left", 32'(exp_q.size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
